seg_page_display: RTL and testbench
===================================

// Module: seg_page_display
// PURPOSE
//  Parametrised multi-page 7-segment display manager for the clock/calendar top level.
//  Takes one BCD-coded digit set per page, selects the active page and drives NUM_DIGITS
//  registered segment outputs. It blinks a contiguous edit field when edit mode is on.
//  Replaces per-screen, hand-coded Hex muxing: page count, digit count, blink rate and
//  segment polarity are all parameters.
// PARAMETERS
//  NUM_DIGITS  8           digits per page; digit 0 is leftmost (HEX7 position)
//  NUM_PAGES   3           display pages (time, date, timezone, ...), >=1
//  BLINK_DIV   25_000_000  clk cycles per blink half-period, >=2
//  ACTIVE_LOW  1           1: segment bit 0 lights the segment (DE2 style); 0: bit 1 lights it
// PORTS
//  clk         in   1                     system clock
//  reset       in   1                     reset, synchronous, active-high
//  page_bcd    in   NUM_PAGES*NUM_DIGITS*4  nibble [(p*NUM_DIGITS+d)*4 +: 4] = page p, digit d
//  page_valid  in   NUM_PAGES             per-page enable mask
//  key_next    in   1                     1-cycle pulse: go to next valid page
//  key_prev    in   1                     1-cycle pulse: go to previous valid page
//  edit_en     in   1                     edit mode active
//  edit_pos    in   $clog2(NUM_DIGITS)    first digit of the blinking field
//  edit_width  in   2                     field length 1..3; 0 is treated as 1
//  seg         out  NUM_DIGITS*7          segments, digit d = seg[d*7 +: 7], bit order g..a
//  page        out  $clog2(NUM_PAGES)     current page index (min width 1)
//  page_ind    out  NUM_PAGES             one-hot current page; all zero when no page is valid
//  blink_phase out  1                     1 = edit field currently blanked
// BEHAVIOUR
//  - Reset: page=0, blink_cnt=0, blink_phase=0, page_ind=0, all seg digits = blank glyph.
//  - All outputs are registered. seg reflects page_bcd/edit inputs with 1 cycle of latency.
//  - Glyphs: nibble 0-9 = decimal digit, 4'hA = '-', 4'hB..4'hF = blank.
//  - Page FSM (register page):
//    * key_next: advance to the next index with page_valid=1, searching upward with wrap.
//      key_prev searches downward with wrap. If no other valid page exists, page is unchanged.
//    * key_next && key_prev in the same cycle: no page change.
//    * Page keys are ignored while edit_en=1. Edits never change page.
//    * If page_valid[page] drops to 0, page moves to the lowest valid index on the next cycle.
//      If no page is valid, page is forced to 0, page_ind=0, and all digits show blank.
//  - Blink timer:
//    * blink_cnt runs 0..BLINK_DIV-1. At the wrap, blink_phase toggles.
//    * The timer runs only while edit_en=1. With edit_en=0: blink_cnt=0, blink_phase=0.
//    * A rising edge of edit_en, or any change of edit_pos, restarts the timer with
//      blink_phase=0. The field is therefore visible for a full half-period after a
//      cursor move.
//  - Field blanking: digit d is blank when edit_en && blink_phase &&
//    edit_pos <= d <= edit_pos+max(edit_width,1)-1. The range is clipped at NUM_DIGITS-1.
//    If edit_pos >= NUM_DIGITS, no digit blinks.
//  - Reset asserted mid-operation overrides everything on the next edge (all reset values).
//  - Width rules: the field-end sum is computed at $clog2(NUM_DIGITS)+2 bits so it cannot
//    wrap. blink_cnt width is $clog2(BLINK_DIV).
// STRUCTURE
//  - Package seg_pkg holds:
//    * glyph code localparams: GLYPH_DASH=4'hA, GLYPH_BLANK=4'hF;
//    * SEG_BLANK and SEG_DASH patterns (active-high form);
//    * function next_valid(mask, cur, dir) shared with other page-based blocks.
//  - One sub-module, seg_decoder: combinational nibble -> 7-bit active-high pattern.
//    It is instantiated NUM_DIGITS times via generate. Polarity inversion is applied
//    once, at the output register.
//  - Top file holds the page FSM, blink timer, field mask and output registers.
// TESTING
//  (Use BLINK_DIV=4, NUM_DIGITS=8, NUM_PAGES=3, ACTIVE_LOW=1 unless noted.)
//  1. Reset held 3 cycles, then released:
//     -> seg = {8{7'h7F}}, page=0, page_ind=0 during reset;
//        1 cycle after release, page_ind=3'b001.
//  2. Page 0 digits = 1,2,3,4,5,6,7,8:
//     -> seg digit0 = 7'h79, digit7 = 7'h00, 1 cycle after input change.
//  3. page_valid=3'b101, key_next pulses x3 -> page sequence 0->2->0->2;
//     then key_prev pulse -> 0; then key_next && key_prev together -> no change.
//  4. edit_en=1, edit_pos=6, edit_width=3:
//     -> digits 6,7 blank only in cycles where blink_phase=1; blink period 8 cycles;
//        phase=0 for 4 cycles after edit_en rises; key_next is ignored.
//  5. While blinking, change edit_pos 0->2:
//     -> blink_phase returns to 0 next cycle; digits 2..4 then blink;
//        digits 0,1 are steady.
//  6. page=2, then page_valid -> 3'b010: next cycle page=1;
//     then page_valid -> 0: page=0, page_ind=0, all digits blank.

Source files
------------

// File: rtl/seg_page_display_pkg.sv
// Shared glyph codes, segment patterns and page-search helper for page-based display blocks.
// Latency: n/a (constants and a combinational function only).
// Backpressure: none; nothing here holds state.
package seg_page_display_pkg;

    // Nibble codes that are not decimal digits.
    localparam logic [3:0] GLYPH_DASH  = 4'hA;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    // Segment patterns in active-high form, bit order g..a.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Widest page mask the search helper accepts.
    localparam int MAX_PAGES = 32;

    // Next set bit of mask starting one step away from cur, walking upward (dir=0)
    // or downward (dir=1) with wrap over n entries. Returns cur when no other bit is set.
    function automatic int next_valid(input logic [MAX_PAGES-1:0] mask,
                                      input int                   cur,
                                      input int                   n,
                                      input logic                 dir);
        int   idx;
        int   res;
        logic found;
        idx   = cur;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i < MAX_PAGES; i++) begin
            if (i < n) begin
                if (dir) idx = (idx == 0) ? n - 1 : idx - 1;
                else     idx = (idx == n - 1) ? 0 : idx + 1;
                if (!found && mask[idx]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_page_display_if.sv
// Bundle of page data, navigation/edit controls and display outputs of seg_page_display.
// Latency: n/a (wires only).
// Backpressure: none; the display consumes its inputs every cycle.
// slave modport: the display manager; master modport: the block feeding it / reading it.
interface seg_page_display_if #(
    parameter int NUM_DIGITS = 8,
    parameter int NUM_PAGES  = 3
);
    localparam int PW = (NUM_PAGES  > 1) ? $clog2(NUM_PAGES)  : 1;
    localparam int EW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [NUM_PAGES*NUM_DIGITS*4-1:0] page_bcd;
    logic [NUM_PAGES-1:0]              page_valid;
    logic                              key_next;
    logic                              key_prev;
    logic                              edit_en;
    logic [EW-1:0]                     edit_pos;
    logic [1:0]                        edit_width;
    logic [NUM_DIGITS*7-1:0]           seg;
    logic [PW-1:0]                     page;
    logic [NUM_PAGES-1:0]              page_ind;
    logic                              blink_phase;

    modport slave (
        input  page_bcd, page_valid, key_next, key_prev, edit_en, edit_pos, edit_width,
        output seg, page, page_ind, blink_phase
    );

    modport master (
        output page_bcd, page_valid, key_next, key_prev, edit_en, edit_pos, edit_width,
        input  seg, page, page_ind, blink_phase
    );

endinterface

// File: rtl/seg_page_display_decoder.sv
// Nibble to 7-segment pattern (active-high, bit order g..a): 0-9 digits, A dash, B-F blank.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble (4-bit glyph code) in, pattern (7-bit segment pattern) out.
module seg_decoder
    import seg_page_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (nibble)
            4'h0:       pattern = 7'h3F;
            4'h1:       pattern = 7'h06;
            4'h2:       pattern = 7'h5B;
            4'h3:       pattern = 7'h4F;
            4'h4:       pattern = 7'h66;
            4'h5:       pattern = 7'h6D;
            4'h6:       pattern = 7'h7D;
            4'h7:       pattern = 7'h07;
            4'h8:       pattern = 7'h7F;
            4'h9:       pattern = 7'h6F;
            GLYPH_DASH: pattern = SEG_DASH;
            default:    pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_page_display.sv
// Multi-page 7-segment display manager: page select FSM, edit-field blink, registered segments.
// Latency: 1 cycle from page_bcd / page_valid / keys / edit inputs to every output.
// Backpressure: none; inputs are sampled every cycle, key pulses act on the cycle they appear.
// Ports: clk, reset (sync, active-high); bus (slave) carries page data, keys, edit controls,
//        seg, page, page_ind and blink_phase.
module seg_page_display
    import seg_page_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int NUM_PAGES  = 3,
    parameter int BLINK_DIV  = 25_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    seg_page_display_if.slave bus
);

    localparam int PW = (NUM_PAGES  > 1) ? $clog2(NUM_PAGES)  : 1;
    localparam int EW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = EW + 2;                 // field end cannot wrap at this width
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
    // XOR mask turning an active-high pattern into the output polarity.
    localparam logic [6:0]    POL      = ACTIVE_LOW ? 7'h7F : 7'h00;

    // ---------------- page FSM ----------------
    logic [PW-1:0]          page_q;
    logic [PW-1:0]          page_nxt;
    logic [PW-1:0]          lowest_valid;
    logic [NUM_PAGES-1:0]   page_ind_q;
    logic [NUM_PAGES-1:0]   page_ind_nxt;
    logic [MAX_PAGES-1:0]   mask_ext;
    logic                   any_valid;

    assign mask_ext  = MAX_PAGES'(bus.page_valid);
    assign any_valid = |bus.page_valid;

    always_comb begin
        lowest_valid = '0;
        for (int p = NUM_PAGES - 1; p >= 0; p--) begin
            if (bus.page_valid[p]) lowest_valid = PW'(p);
        end
    end

    // Losing the current page wins over keys; keys are frozen while editing and
    // cancel each other when pressed together.
    always_comb begin
        page_nxt = page_q;
        if (!any_valid) begin
            page_nxt = '0;
        end else if (!mask_ext[page_q]) begin
            page_nxt = lowest_valid;
        end else if (!bus.edit_en && (bus.key_next ^ bus.key_prev)) begin
            page_nxt = PW'(next_valid(mask_ext, int'(page_q), NUM_PAGES, bus.key_prev));
        end
    end

    assign page_ind_nxt = any_valid ? (NUM_PAGES'(1) << page_nxt) : '0;

    // ---------------- blink timer ----------------
    logic [CW-1:0] blink_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          blink_phase_q;
    logic          phase_nxt;
    logic          edit_en_q;
    logic [EW-1:0] edit_pos_q;

    // Entering edit mode or moving the cursor restarts the timer, so the field is
    // shown for a full half-period before it first blanks.
    always_comb begin
        cnt_nxt   = '0;
        phase_nxt = 1'b0;
        if (bus.edit_en && edit_en_q && (bus.edit_pos == edit_pos_q)) begin
            if (blink_cnt == CNT_LAST) begin
                cnt_nxt   = '0;
                phase_nxt = ~blink_phase_q;
            end else begin
                cnt_nxt   = blink_cnt + 1'b1;
                phase_nxt = blink_phase_q;
            end
        end
    end

    // ---------------- field mask and glyph decode ----------------
    logic [1:0]              width_eff;
    logic [FW-1:0]           field_end;
    logic [NUM_DIGITS*7-1:0] seg_nxt;
    logic [NUM_DIGITS*7-1:0] seg_q;

    assign width_eff = (bus.edit_width == 2'd0) ? 2'd1 : bus.edit_width;
    assign field_end = FW'(bus.edit_pos) + FW'(width_eff) - FW'(1);

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        logic [3:0] nib;
        logic [3:0] dec_in;
        logic [6:0] pat;
        logic       blank;

        assign nib    = bus.page_bcd[(int'(page_nxt) * NUM_DIGITS + d) * 4 +: 4];
        // Digits past NUM_DIGITS-1 do not exist, so the field is clipped for free.
        assign blank  = !any_valid ||
                        (bus.edit_en && phase_nxt &&
                         (FW'(d) >= FW'(bus.edit_pos)) && (FW'(d) <= field_end));
        assign dec_in = blank ? GLYPH_BLANK : nib;

        seg_decoder u_dec (
            .nibble  (dec_in),
            .pattern (pat)
        );

        assign seg_nxt[d*7 +: 7] = pat ^ POL;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            page_q        <= '0;
            page_ind_q    <= '0;
            blink_cnt     <= '0;
            blink_phase_q <= 1'b0;
            edit_en_q     <= 1'b0;
            edit_pos_q    <= '0;
            seg_q         <= {NUM_DIGITS{SEG_BLANK ^ POL}};
        end else begin
            page_q        <= page_nxt;
            page_ind_q    <= page_ind_nxt;
            blink_cnt     <= cnt_nxt;
            blink_phase_q <= phase_nxt;
            edit_en_q     <= bus.edit_en;
            edit_pos_q    <= bus.edit_pos;
            seg_q         <= seg_nxt;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.page        = page_q;
    assign bus.page_ind    = page_ind_q;
    assign bus.blink_phase = blink_phase_q;

endmodule

// File: tb/tb_seg_page_display.sv
// Scoreboard bench for seg_page_display: stimulus queues the expected outputs for the
// cycle after it drives inputs; a monitor pops one entry per clock and compares.
// Config: NUM_DIGITS=8, NUM_PAGES=3, BLINK_DIV=4, ACTIVE_LOW=1.
module tb_seg_page_display;

    localparam int ND = 8;
    localparam int NP = 3;
    localparam int BD = 4;

    logic clk;
    logic reset;

    seg_page_display_if #(.NUM_DIGITS(ND), .NUM_PAGES(NP)) bus ();

    seg_page_display #(
        .NUM_DIGITS (ND),
        .NUM_PAGES  (NP),
        .BLINK_DIV  (BD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   id;
        logic [55:0]   seg;
        logic [1:0]    page;
        logic [2:0]    ind;
        logic          ph;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         step_no = 0;
    logic [3:0] bcd [NP][ND];

    // Active-low glyphs, hand-written (bit order g..a).
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req,
                       input int id);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h, expected %0h", nm, id, act, req);
        end
    endtask

    task automatic drive_bcd();
        for (int p = 0; p < NP; p++)
            for (int d = 0; d < ND; d++)
                bus.page_bcd[(p*ND + d)*4 +: 4] = bcd[p][d];
    endtask

    // Drive current inputs for one clock and queue what the outputs must be after it.
    task automatic step(input int pg, input logic [2:0] ind, input logic ph,
                        input logic [7:0] blank);
        exp_t e;
        drive_bcd();
        e.id   = 16'(step_no);
        e.page = 2'(pg);
        e.ind  = ind;
        e.ph   = ph;
        for (int d = 0; d < ND; d++)
            e.seg[d*7 +: 7] = ((ind == 3'b000) || blank[d]) ? 7'h7F : glyph(bcd[pg][d]);
        q.push_back(e);
        step_no++;
        @(negedge clk);
        bus.key_next = 1'b0;
        bus.key_prev = 1'b0;
    endtask

    // Monitor: the display presents a new output every clock.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            cmp("seg",         64'(bus.seg),         64'(mon_e.seg),  int'(mon_e.id));
            cmp("page",        64'(bus.page),        64'(mon_e.page), int'(mon_e.id));
            cmp("page_ind",    64'(bus.page_ind),    64'(mon_e.ind),  int'(mon_e.id));
            cmp("blink_phase", 64'(bus.blink_phase), 64'(mon_e.ph),   int'(mon_e.id));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
        $fatal(1, "timeout");
    end

    logic ph;

    initial begin
        reset          = 1'b1;
        bus.page_valid = 3'b111;
        bus.key_next   = 1'b0;
        bus.key_prev   = 1'b0;
        bus.edit_en    = 1'b0;
        bus.edit_pos   = '0;
        bus.edit_width = 2'd0;
        for (int d = 0; d < ND; d++) begin
            bcd[0][d] = 4'(d + 1);          // 1..8
            bcd[2][d] = 4'(9 - d);          // 9..2
        end
        bcd[1][0] = 4'h0; bcd[1][1] = 4'h9; bcd[1][2] = 4'hA; bcd[1][3] = 4'hB;
        bcd[1][4] = 4'h3; bcd[1][5] = 4'hA; bcd[1][6] = 4'h5; bcd[1][7] = 4'hF;

        // reset held, then released
        repeat (3) step(0, 3'b000, 1'b0, 8'h00);
        reset = 1'b0;
        step(0, 3'b001, 1'b0, 8'h00);
        bcd[0][0] = 4'h0; bcd[0][7] = 4'hA;
        step(0, 3'b001, 1'b0, 8'h00);
        bcd[0][0] = 4'h1; bcd[0][7] = 4'h8;
        step(0, 3'b001, 1'b0, 8'h00);

        // navigation over a sparse mask
        bus.page_valid = 3'b101;
        step(0, 3'b001, 1'b0, 8'h00);
        bus.key_next = 1'b1; step(2, 3'b100, 1'b0, 8'h00);
        step(2, 3'b100, 1'b0, 8'h00);
        bus.key_next = 1'b1; step(0, 3'b001, 1'b0, 8'h00);
        bus.key_next = 1'b1; step(2, 3'b100, 1'b0, 8'h00);
        bus.key_prev = 1'b1; step(0, 3'b001, 1'b0, 8'h00);
        bus.key_next = 1'b1; bus.key_prev = 1'b1; step(0, 3'b001, 1'b0, 8'h00);

        // full mask, wrap both ways
        bus.page_valid = 3'b111;
        bus.key_prev = 1'b1; step(2, 3'b100, 1'b0, 8'h00);
        bus.key_prev = 1'b1; step(1, 3'b010, 1'b0, 8'h00);
        bus.key_next = 1'b1; step(2, 3'b100, 1'b0, 8'h00);
        bus.key_next = 1'b1; step(0, 3'b001, 1'b0, 8'h00);

        // single valid page: keys have nowhere to go
        bus.page_valid = 3'b001;
        bus.key_next = 1'b1; step(0, 3'b001, 1'b0, 8'h00);
        bus.key_prev = 1'b1; step(0, 3'b001, 1'b0, 8'h00);
        bus.page_valid = 3'b101;

        // edit field 6..8 clipped to 6..7; keys ignored while editing
        bus.edit_en = 1'b1; bus.edit_pos = 3'd6; bus.edit_width = 2'd3;
        for (int i = 0; i < 16; i++) begin
            if (i == 2 || i == 9) bus.key_next = 1'b1;
            ph = 1'(i / 4);
            step(0, 3'b001, ph, ph ? 8'hC0 : 8'h00);
        end

        // cursor moves restart the blink
        bus.edit_pos = 3'd0;
        for (int i = 0; i < 6; i++) begin
            ph = (i >= 4);
            step(0, 3'b001, ph, ph ? 8'h07 : 8'h00);
        end
        bus.edit_pos = 3'd2;
        for (int i = 0; i < 8; i++) begin
            ph = (i >= 4);
            step(0, 3'b001, ph, ph ? 8'h1C : 8'h00);
        end

        // width 0 behaves as width 1
        bus.edit_pos = 3'd5; bus.edit_width = 2'd0;
        for (int i = 0; i < 8; i++) begin
            ph = (i >= 4);
            step(0, 3'b001, ph, ph ? 8'h20 : 8'h00);
        end
        bus.edit_en = 1'b0;
        step(0, 3'b001, 1'b0, 8'h00);

        // losing the current page, then losing every page
        bus.key_next = 1'b1; step(2, 3'b100, 1'b0, 8'h00);
        bus.page_valid = 3'b010; step(1, 3'b010, 1'b0, 8'h00);
        bus.page_valid = 3'b000; step(0, 3'b000, 1'b0, 8'h00);
        bus.key_next = 1'b1; step(0, 3'b000, 1'b0, 8'h00);
        bus.page_valid = 3'b111; step(0, 3'b001, 1'b0, 8'h00);

        // reset in the middle of editing
        bus.key_next = 1'b1; step(1, 3'b010, 1'b0, 8'h00);
        bus.edit_en = 1'b1; bus.edit_pos = 3'd0;
        step(1, 3'b010, 1'b0, 8'h00);
        step(1, 3'b010, 1'b0, 8'h00);
        reset = 1'b1; step(0, 3'b000, 1'b0, 8'h00);
        reset = 1'b0; bus.edit_en = 1'b0; step(0, 3'b001, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        cmp("queue_drained", 64'(q.size()), 64'd0, step_no);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
